// File: rtl/matmul_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_ctrl_if
// Description : Flat-bus job interface for the sequential matrix multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface matmul_seq_ctrl_if #(
   parameter int N = 2,
   parameter int W = 32
);
   logic               start;
   logic [W*N*N-1:0]   mat_a;
   logic [W*N*N-1:0]   mat_b;
   logic               busy;
   logic               done;
   logic [W*N*N-1:0]   mat_c;

   modport master (
      output start, mat_a, mat_b,
      input  busy, done, mat_c
   );

   modport slave (
      input  start, mat_a, mat_b,
      output busy, done, mat_c
   );
endinterface
`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_ctrl
// Description : Time-shared single-MAC n x n matrix multiplier controller.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl #(
   parameter int N = 2,
   parameter int W = 32
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   matmul_seq_ctrl_if.slave   bus
);
   localparam int              c_cw   = (N > 1) ? $clog2(N) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_busy;
   logic              r_done;

   logic [W-1:0]      w_a_in [N][N];
   logic [W-1:0]      w_b_in [N][N];
   logic [W-1:0]      r_a    [N][N];
   logic [W-1:0]      r_b    [N][N];
   logic [W-1:0]      r_c    [N][N];
   logic [W*N*N-1:0]  w_c_flat;

   logic [c_cw-1:0]   r_i;
   logic [c_cw-1:0]   r_j;
   logic [c_cw-1:0]   r_k;
   logic [W-1:0]      r_acc;
   logic [W-1:0]      w_prod;
   logic [W-1:0]      w_sum;
   logic              w_last;

   // Column-major unpacking: element (r, c) sits at flat index r + N*c.
   generate
      for (genvar gr = 0; gr < N; gr++) begin : g_row
         for (genvar gc = 0; gc < N; gc++) begin : g_col
            assign w_a_in[gr][gc]                   = bus.mat_a[(gr + N*gc)*W +: W];
            assign w_b_in[gr][gc]                   = bus.mat_b[(gr + N*gc)*W +: W];
            assign w_c_flat[(gr + N*gc)*W +: W]     = r_c[gr][gc];
         end
      end
   endgenerate

   assign bus.mat_c = w_c_flat;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

   assign w_prod = r_a[r_i][r_j] * r_b[r_j][r_k];
   assign w_sum  = ((r_j == '0) ? '0 : r_acc) + w_prod;
   assign w_last = (r_i == c_last) && (r_j == c_last) && (r_k == c_last);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they align with r_state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i   <= '0;
         r_j   <= '0;
         r_k   <= '0;
         r_acc <= '0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_a[r][c] <= '0;
               r_b[r][c] <= '0;
               r_c[r][c] <= '0;
            end
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_i   <= '0;
                  r_j   <= '0;
                  r_k   <= '0;
                  r_acc <= '0;
                  for (int r = 0; r < N; r++) begin
                     for (int c = 0; c < N; c++) begin
                        r_a[r][c] <= w_a_in[r][c];
                        r_b[r][c] <= w_b_in[r][c];
                     end
                  end
               end
            end
            S_RUN: begin
               if (r_j != c_last) begin
                  r_acc <= w_sum;
                  r_j   <= r_j + c_one;
               end else begin
                  r_c[r_i][r_k] <= w_sum;
                  r_j           <= '0;
                  // i advances per finished dot product; k only when i wraps.
                  if (r_i == c_last) begin
                     r_i <= '0;
                     r_k <= (r_k == c_last) ? '0 : r_k + c_one;
                  end else begin
                     r_i <= r_i + c_one;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_matmul_seq_ctrl
// Description : Self-checking bench for matmul_seq_ctrl (N=2/W=32 and N=1/W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_seq_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   matmul_seq_ctrl_if #(.N(2), .W(32)) bus ();
   matmul_seq_ctrl_if #(.N(1), .W(8))  bus1 ();

   matmul_seq_ctrl #(.N(2), .W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   matmul_seq_ctrl #(.N(1), .W(8)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      string          name;
      logic [127:0]   a;
      logic [127:0]   b;
      logic [127:0]   c;
   } vec_t;

   vec_t          vecs [5];
   logic [127:0]  sb [$];
   int            n_vec  = 0;
   int            n_fail = 0;

   function automatic logic [127:0] pk(input logic [31:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must consume one expected result.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 with no job pending, want done=0");
         end else begin
            chk("scoreboard_mat_c", bus.mat_c, sb.pop_front());
         end
      end
   end

   // mode 0: plain job; mode 1: zero mat_a + start pulse mid-run; mode 2: reset at cycle 5
   task automatic run_job(input string nm, input logic [127:0] a, b, c, input int mode);
      int lat;
      int busy_cnt;
      int extra;
      bit seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mat_a = a;
      bus.mat_b = b;
      sb.push_back(c);
      @(negedge clk);
      bus.start = 1'b0;
      lat      = 0;
      busy_cnt = 0;
      seen     = 1'b0;
      while (lat < 40) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cnt++;
         if (mode == 1 && lat == 3) begin
            bus.mat_a = '0;
            bus.start = 1'b1;
         end
         if (mode == 1 && lat == 4) bus.start = 1'b0;
         if (mode == 2 && lat == 5) begin
            #2 rst_n = 1'b0;
            #1;
            chk({nm, "_rst_busy"},  128'(bus.busy),  128'(0));
            chk({nm, "_rst_done"},  128'(bus.done),  128'(0));
            chk({nm, "_rst_mat_c"}, bus.mat_c,       128'(0));
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
         lat++;
      end
      chk({nm, "_done_seen"},    128'(seen),      128'(1));
      chk({nm, "_latency"},      128'(lat),       128'(8));
      chk({nm, "_busy_cycles"},  128'(busy_cnt),  128'(8));
      chk({nm, "_busy_at_done"}, 128'(bus.busy),  128'(0));
      @(negedge clk);
      chk({nm, "_done_width"},   128'(bus.done),  128'(0));
      if (mode == 1) begin
         extra = 0;
         for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (bus.done) extra++;
         end
         chk({nm, "_no_second_done"}, 128'(extra), 128'(0));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      int last;
      vecs[0] = '{"basic",    pk(1, 0, 10, 1), pk(1, 0, 1, 1), pk(1, 0, 11, 1)};
      vecs[1] = '{"wrap",     {4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, pk(2, 2, 2, 2)};
      vecs[2] = '{"ident",    pk(1, 0, 0, 1), pk(5, 6, 7, 8), pk(5, 6, 7, 8)};
      vecs[3] = '{"general",  pk(2, 3, 4, 5), pk(6, 7, 8, 9), pk(40, 53, 52, 69)};
      vecs[4] = '{"modulo",   pk(32'h8000_0000, 3, 32'h7FFF_FFFF, 0), pk(2, 0, 0, 2),
                              pk(0, 6, 32'hFFFF_FFFE, 0)};

      bus.start  = 1'b0;
      bus.mat_a  = '0;
      bus.mat_b  = '0;
      bus1.start = 1'b0;
      bus1.mat_a = '0;
      bus1.mat_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy",  128'(bus.busy),  128'(0));
      chk("reset_done",  128'(bus.done),  128'(0));
      chk("reset_mat_c", bus.mat_c,       128'(0));
      chk("reset_n1_mat_c", 128'(bus1.mat_c), 128'(0));
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         run_job(vecs[v].name, vecs[v].a, vecs[v].b, vecs[v].c, 0);
      end

      run_job("isolation", vecs[3].a, vecs[3].b, vecs[3].c, 1);

      run_job("reset_mid_run", vecs[3].a, vecs[3].b, vecs[3].c, 2);
      repeat (2) @(negedge clk);
      chk("post_reset_busy", 128'(bus.busy), 128'(0));
      run_job("basic_after_reset", vecs[0].a, vecs[0].b, vecs[0].c, 0);

      // Back-to-back: start held high, acceptance only in IDLE.
      @(negedge clk);
      bus.start = 1'b1;
      bus.mat_a = vecs[2].a;
      bus.mat_b = vecs[2].b;
      repeat (3) sb.push_back(vecs[2].c);
      ndone = 0;
      last  = 0;
      for (int cyc = 1; cyc <= 60 && ndone < 3; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            if (ndone > 1) chk("b2b_period", 128'(cyc - last), 128'(10));
            last = cyc;
            if (ndone == 3) bus.start = 1'b0;
         end
      end
      chk("b2b_done_count", 128'(ndone), 128'(3));
      repeat (15) @(negedge clk);
      chk("b2b_idle_busy", 128'(bus.busy), 128'(0));

      // N=1, W=8 instance: one-cycle RUN, product truncated to 8 bits.
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.mat_a = 8'd16;
      bus1.mat_b = 8'd17;
      @(negedge clk);
      bus1.start = 1'b0;
      chk("n1_busy_run",  128'(bus1.busy),  128'(1));
      chk("n1_done_run",  128'(bus1.done),  128'(0));
      @(negedge clk);
      chk("n1_done",      128'(bus1.done),  128'(1));
      chk("n1_busy_done", 128'(bus1.busy),  128'(0));
      chk("n1_mat_c",     128'(bus1.mat_c), 128'(8'h10));
      @(negedge clk);
      chk("n1_done_width", 128'(bus1.done), 128'(0));

      chk("sb_drained", 128'(sb.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequential controller for n×n matrix multiplication. It accepts flat-packed operand matrices with a start pulse and latches them. It then runs the product through a single time-shared multiply-accumulate datapath, one MAC per clock, and reports completion with a done pulse. It is the area-saving alternative to the fully parallel multiplier array: N³ cycles of latency for one multiplier and one adder instead of N³ multipliers. It uses the same packing and arithmetic rules as that array, so the two are interchangeable behind the same flat-bus interface.

## Interface

- N, default 2: matrix dimension; N ≥ 1.
- W, default 32: element width in bits.

- clk  in  1: sole clock; all state updates on its rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: request a multiplication; sampled only in IDLE.
- mat_a  in  W·N·N: operand A.
- mat_b  in  W·N·N: operand B.
- busy  out  1: high while in RUN.
- done  out  1: single-cycle completion pulse.
- mat_c  out  W·N·N: registered result C = A·B.

Packing is column-major for all three buses. Element (row r, col c) occupies bits [(r + N·c)·W + W−1 : (r + N·c)·W].

## Operation

- States:
  - IDLE: waiting for start.
  - RUN: one MAC per cycle.
  - DONE: single cycle, done=1.
- IDLE → RUN when start=1 at an edge. On that edge:
  - mat_a and mat_b are copied into internal operand registers.
  - Counters i, k and j are cleared.
  - The accumulator is cleared.
- Operand changes after acceptance have no effect on the current job.
- RUN, each edge:
  - Compute sum = (j==0 ? 0 : acc) + A[i][j]·B[j][k].
  - If j < N−1: acc ← sum, j ← j+1.
  - If j == N−1: C[i][k] ← sum and j ← 0. Advance i; when i wraps from N−1 to 0, advance k.
  - On the edge that writes C[N−1][N−1], go to DONE.
- Iteration order: j innermost, then i, then k (outermost). C is filled in packed-index order 0, 1, …, N²−1.
- DONE → IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE; there is no queuing.
- Arithmetic:
  - Product truncated to the low W bits.
  - Sum taken modulo 2^W.
  - Unsigned; no saturation or overflow flag.
- mat_c elements not yet overwritten keep their previous value. mat_c is guaranteed complete and correct only from the done cycle until the next accepted start.
- N=1: RUN lasts one cycle; counters stay at 0.
- Counter widths are max(1, clog2(N)) bits.
- rst_n low at any time, including mid-RUN:
  - state → IDLE; busy=0; done=0.
  - mat_c = 0; counters, accumulator and operand registers = 0.
  - The job in progress is discarded.

## Timing

- Reset values: busy=0, done=0, mat_c=0.
- Call the start-accept edge E0.
- busy=1 from just after E0 through the cycle ending at edge E(N³).
- The final element is written at E(N³).
- done=1 for exactly one cycle, between E(N³) and E(N³+1). busy=0 in that cycle.
- Start-to-done latency: N³ cycles after the acceptance edge. For N=2 this is 8 cycles.
- Earliest next acceptance: start high at E(N³+2), the first edge seen in IDLE.
- Throughput: one job per N³+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Basic product, N=2:
  - Stimulus: mat_a elements [0..3] = 1, 0, 10, 1 and mat_b = 1, 0, 1, 1.
  - Required: mat_c = 1, 0, 11, 1 with done; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- Wrap-around:
  - Stimulus: every element of mat_a and mat_b = 0xFFFFFFFF.
  - Required: every mat_c element = 2 (each product truncates to 1).
- Operand isolation and start-while-busy:
  - Stimulus: change mat_a to all zeros and pulse start at cycle 3 of a RUN.
  - Required: the result still matches the latched operands; no second done appears; busy timing is unchanged.
- Reset mid-RUN:
  - Stimulus: drop rst_n asynchronously at cycle 5 of a RUN.
  - Required: busy=0, done=0 and mat_c=0 immediately. After release, a new start with the basic-product operands yields 1, 0, 11, 1.
- Back-to-back jobs:
  - Stimulus: hold start high continuously with identity A and B = 5, 6, 7, 8.
  - Required: mat_c = 5, 6, 7, 8. done pulses every 10 cycles. Each start is accepted only in IDLE.
- N=1, W=8:
  - Stimulus: A = 16, B = 17.
  - Required: done 1 cycle after the start edge; mat_c = 0x10 (272 mod 256 = 16).
